mem_arbiter: RTL
================

# mem_arbiter

Parametrised memory-port arbiter placed between the CPU bus, the ROM/program downloader and the board memories (block RAMs and SDRAM). It merges CPU accesses, buffered downloader writes and a built-in memory eraser onto one write/read port. The CPU is never stalled, downloads are never lost below FIFO capacity, and a power-on style RAM clear runs in the background.

## Interface
Parameters:
- ADDR_W, 25, memory address width; the CPU address is zero-extended to this width.
- DATA_W, 8, data width.
- FIFO_DEPTH, 4, download write buffer entries; power of two, at least 2.
- ERASE_START, 'h0000, first address cleared by the eraser.
- ERASE_END, 'hBFFF, last address cleared (inclusive); at least ERASE_START.
- ERASE_DATA, 8'h00, value written by the eraser.

Ports:
- sys_clock  in  1  system clock; every cycle is one memory slot.
- reset  in  1  asynchronous, active-high.
- cpu_clken  in  1  CPU clock enable; marks the CPU slot.
- cpu_addr  in  16  CPU address.
- cpu_dout  in  DATA_W  CPU write data.
- cpu_wr  in  1  CPU write strobe; sampled only when cpu_clken=1.
- dl_wr  in  1  downloader write request, one per cycle.
- dl_addr  in  ADDR_W  downloader address.
- dl_data  in  DATA_W  downloader data.
- dl_full  out  1  FIFO holds FIFO_DEPTH entries.
- dl_drop_cnt  out  8  saturating count of rejected downloader writes.
- erase_start  in  1  start-erase pulse.
- erase_busy  out  1  eraser running.
- mem_addr  out  ADDR_W  memory address.
- mem_din  out  DATA_W  memory write data.
- mem_wr  out  1  memory write strobe.
- mem_rd  out  1  memory read strobe.
- mem_owner  out  2  slot owner: 0 = CPU/idle, 1 = download, 2 = eraser.

## Operation
- Slot priority each cycle:
  - cpu_clken=1: CPU owns the slot.
  - else FIFO non-empty: download owns the slot.
  - else eraser in RUN: eraser owns the slot.
  - else idle.
- CPU slot:
  - mem_addr = zero-extended cpu_addr.
  - mem_din = cpu_dout.
  - mem_wr = cpu_wr; mem_rd = !cpu_wr.
- Idle slot: same as the CPU slot, but mem_wr=0 and mem_rd=1.
- Download slot:
  - mem_addr and mem_din = FIFO head.
  - mem_wr=1, mem_rd=0.
  - FIFO pops at the end of the cycle.
- Eraser slot:
  - mem_addr = erase pointer; mem_din = ERASE_DATA.
  - mem_wr=1, mem_rd=0.
  - Pointer increments at the end of the cycle.
- FIFO push when dl_wr=1 and (count<FIFO_DEPTH, or a pop happens in the same cycle).
  - Full with no pop: the write is dropped and dl_drop_cnt increments, saturating at 255.
  - Push and pop in the same cycle leave the count unchanged.
- Eraser FSM:
  - IDLE: erase_start=1 loads pointer=ERASE_START and goes to RUN.
  - RUN: erase_busy=1. After the slot that writes ERASE_END, return to IDLE.
  - erase_start while in RUN is ignored; no restart.
  - The eraser stalls (pointer held) in every CPU or download slot.

## Timing
- Reset values: FIFO empty, dl_full=0, dl_drop_cnt=0, eraser IDLE, erase_busy=0, mem_owner=0, mem_wr=0, mem_rd=1, mem_addr = zero-extended cpu_addr.
- mem_* and mem_owner are combinational from the slot decision. Sources are the current CPU inputs, the registered FIFO head and the registered erase pointer.
- Download latency:
  - A write pushed in cycle n appears on mem_* no earlier than cycle n+1.
  - It appears in the first non-CPU slot after all older entries.
- Eraser:
  - erase_busy rises the cycle after erase_start.
  - Duration = (ERASE_END-ERASE_START+1) eraser slots plus stalled cycles.
  - erase_busy falls the cycle after the ERASE_END write.
- dl_full and dl_drop_cnt are registered and update the cycle after the push/pop/drop event.
- Reset asserted mid-operation: the FIFO is discarded and the eraser aborts immediately; no partial state survives reset deassertion.
- Simultaneous events resolve by slot priority. No request is ever granted two slots in one cycle.

## Configuration
- MEM_ERASER_EN:
  - Defined: eraser FSM, pointer and erase_busy are implemented as above.
  - Undefined: no eraser logic; erase_start is ignored, erase_busy is tied 0, and mem_owner never equals 2.
  - CPU and download behaviour is identical in both builds.

## Test plan
- CPU only, cpu_clken every 7th cycle, cpu_wr=1, addr 'h0300, data 'hA5:
  - Write appears with mem_owner=0, mem_wr=1 only in clken cycles.
  - All other cycles are idle with mem_wr=0.
- Burst of 6 dl_wr in consecutive cycles, FIFO_DEPTH=4, cpu_clken held 1:
  - 4 entries accepted, dl_full=1, dl_drop_cnt=2.
  - After clken drops, 4 writes are issued in order on consecutive cycles.
- dl_wr every cycle while the FIFO drains with cpu_clken=0:
  - Simultaneous push/pop holds the count.
  - No drops; all addresses are written exactly once and in order.
- erase_start with ERASE_START='h10, ERASE_END='h13, no other traffic:
  - Writes of 'h00 to 'h10..'h13 on 4 consecutive cycles.
  - erase_busy high for exactly 4 cycles.
- Erase of 'h0000..'h00FF interleaved with cpu_clken 1-in-7 and 3 download writes:
  - Every erase address is written once.
  - Downloads precede pending erase slots; CPU slots are never displaced.
- Reset pulse in the middle of an erase with 2 FIFO entries pending:
  - All outputs return to reset values asynchronously.
  - No further eraser or download writes after deassertion.

Source files
------------

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: CPU slots first, then buffered downloader writes, then the background eraser.
// Optional eraser is built only when MEM_ERASER_EN is defined.
module mem_arbiter #(
   parameter int                ADDR_W      = 25,
   parameter int                DATA_W      = 8,
   parameter int                FIFO_DEPTH  = 4,
   parameter logic [ADDR_W-1:0] ERASE_START = 'h0000,
   parameter logic [ADDR_W-1:0] ERASE_END   = 'hBFFF,
   parameter logic [DATA_W-1:0] ERASE_DATA  = 8'h00
) (
   input  logic              sys_clock,
   input  logic              reset,
   input  logic              cpu_clken,
   input  logic [15:0]       cpu_addr,
   input  logic [DATA_W-1:0] cpu_dout,
   input  logic              cpu_wr,
   input  logic              dl_wr,
   input  logic [ADDR_W-1:0] dl_addr,
   input  logic [DATA_W-1:0] dl_data,
   output logic              dl_full,
   output logic [7:0]        dl_drop_cnt,
   input  logic              erase_start,
   output logic              erase_busy,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   output logic              mem_wr,
   output logic              mem_rd,
   output logic [1:0]        mem_owner
);

   localparam int PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
   logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
   logic [PTR_W-1:0]  rd_ptr_reg, wr_ptr_reg;
   logic [CNT_W-1:0]  count_reg, count_next;
   logic              full_reg;
   logic [7:0]        drop_cnt_reg;
   logic              fifo_empty, fifo_pop, fifo_push;
   logic              erase_slot;
   logic [ADDR_W-1:0] erase_ptr;

   assign fifo_empty = (count_reg == '0);
   assign fifo_pop   = !cpu_clken && !fifo_empty;
   // A full FIFO still accepts a write when its head leaves in the same slot.
   assign fifo_push  = dl_wr && ((count_reg != CNT_W'(FIFO_DEPTH)) || fifo_pop);

   always_comb begin
      count_next = count_reg;
      if (fifo_push && !fifo_pop)
         count_next = count_reg + CNT_W'(1);
      else if (fifo_pop && !fifo_push)
         count_next = count_reg - CNT_W'(1);
   end

   always_ff @(posedge sys_clock or posedge reset) begin
      if (reset) begin
         rd_ptr_reg   <= '0;
         wr_ptr_reg   <= '0;
         count_reg    <= '0;
         full_reg     <= 1'b0;
         drop_cnt_reg <= '0;
      end else begin
         count_reg <= count_next;
         full_reg  <= (count_next == CNT_W'(FIFO_DEPTH));
         if (fifo_pop)
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         if (fifo_push)
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (dl_wr && !fifo_push && drop_cnt_reg != 8'hFF)
            drop_cnt_reg <= drop_cnt_reg + 8'd1;
      end
   end

   // Storage carries no reset: entries are only visible through count_reg.
   always_ff @(posedge sys_clock) begin
      if (fifo_push) begin
         fifo_addr[wr_ptr_reg] <= dl_addr;
         fifo_data[wr_ptr_reg] <= dl_data;
      end
   end

   assign dl_full     = full_reg;
   assign dl_drop_cnt = drop_cnt_reg;

`ifdef MEM_ERASER_EN
   typedef enum logic {ER_IDLE, ER_RUN} er_state_t;
   er_state_t         state_reg, state_next;
   logic [ADDR_W-1:0] ptr_reg, ptr_next;

   assign erase_slot = (state_reg == ER_RUN) && !cpu_clken && fifo_empty;
   assign erase_ptr  = ptr_reg;
   assign erase_busy = (state_reg == ER_RUN);

   always_ff @(posedge sys_clock or posedge reset) begin
      if (reset) begin
         state_reg <= ER_IDLE;
         ptr_reg   <= '0;
      end else begin
         state_reg <= state_next;
         ptr_reg   <= ptr_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      ptr_next   = ptr_reg;
      case (state_reg)
         ER_IDLE: begin
            if (erase_start) begin
               state_next = ER_RUN;
               ptr_next   = ERASE_START;
            end
         end
         ER_RUN: begin
            // Pointer only moves in slots the eraser actually owns.
            if (erase_slot) begin
               ptr_next = ptr_reg + ADDR_W'(1);
               if (ptr_reg == ERASE_END)
                  state_next = ER_IDLE;
            end
         end
         default: state_next = ER_IDLE;
      endcase
   end
`else
   logic unused_erase;
   assign unused_erase = erase_start ^ (^ERASE_END);
   assign erase_slot   = 1'b0;
   assign erase_ptr    = ERASE_START;
   assign erase_busy   = 1'b0;
`endif

   always_comb begin
      mem_addr  = ADDR_W'(cpu_addr);
      mem_din   = cpu_dout;
      mem_wr    = 1'b0;
      mem_rd    = 1'b1;
      mem_owner = 2'd0;
      if (cpu_clken) begin
         mem_wr = cpu_wr;
         mem_rd = !cpu_wr;
      end else if (!fifo_empty) begin
         mem_addr  = fifo_addr[rd_ptr_reg];
         mem_din   = fifo_data[rd_ptr_reg];
         mem_wr    = 1'b1;
         mem_rd    = 1'b0;
         mem_owner = 2'd1;
      end else if (erase_slot) begin
         mem_addr  = erase_ptr;
         mem_din   = ERASE_DATA;
         mem_wr    = 1'b1;
         mem_rd    = 1'b0;
         mem_owner = 2'd2;
      end
   end

endmodule
